// File: rtl/hc595_rx_if.sv
// Bus bundle for the HC595 capture block: the eight serial link lines plus the rebuilt frame outputs.
// The master modport is the link/monitor side; the slave modport is the hc595_rx receiver.
interface hc595_rx_if #(
  parameter int CNT_W = 16
);
  logic             shcp;
  logic             stcp;
  logic             ds0;
  logic             ds1;
  logic             ds2;
  logic             ds3;
  logic             ds4;
  logic             ds5;
  logic [39:0]      led_frame;
  logic             frame_valid;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output shcp, stcp, ds0, ds1, ds2, ds3, ds4, ds5,
    input  led_frame, frame_valid, frame_err, frame_cnt
  );

  modport slave (
    input  shcp, stcp, ds0, ds1, ds2, ds3, ds4, ds5,
    output led_frame, frame_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/hc595_rx.sv
// Rebuilds the 40-bit LED frame from the 6-lane HC595 link (4 long 8-bit lanes, 2 short 4-bit lanes).
// Define HC595_RX_SYNC_EN to add a 2-flop synchronizer on all eight serial inputs (+2 cycles latency).
module hc595_rx #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  hc595_rx_if.slave   bus
);

  // Packed input order: {shcp, stcp, ds5, ds4, ds3, ds2, ds1, ds0}
  localparam logic [7:0] IN_RST = 8'b1100_0000;

  logic [7:0] in_raw;
  logic [7:0] in_s;

  assign in_raw = {bus.shcp, bus.stcp, bus.ds5, bus.ds4, bus.ds3, bus.ds2, bus.ds1, bus.ds0};

`ifdef HC595_RX_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
  end

  // Clock lines reset high so a line held high across reset never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= IN_RST;
      sync2_q <= IN_RST;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = in_raw;
`endif

  logic             shcp_prev_q, shcp_prev_d;
  logic             stcp_prev_q, stcp_prev_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       lane0_q, lane0_d;
  logic [7:0]       lane1_q, lane1_d;
  logic [3:0]       lane2_q, lane2_d;
  logic [7:0]       lane3_q, lane3_d;
  logic [7:0]       lane4_q, lane4_d;
  logic [3:0]       lane5_q, lane5_d;
  logic [39:0]      led_frame_q, led_frame_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic shcp_rise;
  logic stcp_rise;

  assign shcp_rise = in_s[7] & ~shcp_prev_q;
  assign stcp_rise = in_s[6] & ~stcp_prev_q;

  always_comb begin
    shcp_prev_d   = in_s[7];
    stcp_prev_d   = in_s[6];
    bit_cnt_d     = bit_cnt_q;
    lane0_d       = lane0_q;
    lane1_d       = lane1_q;
    lane2_d       = lane2_q;
    lane3_d       = lane3_q;
    lane4_d       = lane4_q;
    lane5_d       = lane5_q;
    led_frame_d   = led_frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (shcp_rise) begin
      lane0_d = {lane0_q[6:0], in_s[0]};
      lane1_d = {lane1_q[6:0], in_s[1]};
      lane3_d = {lane3_q[6:0], in_s[3]};
      lane4_d = {lane4_q[6:0], in_s[4]};
      if (bit_cnt_q < 4'd4) begin
        lane2_d = {lane2_q[2:0], in_s[2]};
        lane5_d = {lane5_q[2:0], in_s[5]};
      end
      if (bit_cnt_q != 4'hF) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    // A shift in the latch cycle belongs to the frame, so judge on the updated count and lanes
    if (stcp_rise) begin
      if (bit_cnt_d == 4'd8) begin
        led_frame_d   = {lane0_d, lane1_d, lane2_d, lane3_d, lane4_d, lane5_d};
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      end else begin
        frame_err_d = 1'b1;
      end
      bit_cnt_d = 4'd0;
      lane0_d   = 8'd0;
      lane1_d   = 8'd0;
      lane2_d   = 4'd0;
      lane3_d   = 8'd0;
      lane4_d   = 8'd0;
      lane5_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shcp_prev_q   <= 1'b1;
      stcp_prev_q   <= 1'b1;
      bit_cnt_q     <= 4'd0;
      lane0_q       <= 8'd0;
      lane1_q       <= 8'd0;
      lane2_q       <= 4'd0;
      lane3_q       <= 8'd0;
      lane4_q       <= 8'd0;
      lane5_q       <= 4'd0;
      led_frame_q   <= 40'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      shcp_prev_q   <= shcp_prev_d;
      stcp_prev_q   <= stcp_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      lane0_q       <= lane0_d;
      lane1_q       <= lane1_d;
      lane2_q       <= lane2_d;
      lane3_q       <= lane3_d;
      lane4_q       <= lane4_d;
      lane5_q       <= lane5_d;
      led_frame_q   <= led_frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.led_frame   = led_frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Bench for hc595_rx: a frame-level model (queue of received bit slices per latch) checked every cycle,
// plus literal expectations for each directed scenario. Honours HC595_RX_SYNC_EN for the extra latency.
module tb_hc595_rx;

`ifdef HC595_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst;

  hc595_rx_if #(.CNT_W(16)) bus ();

  hc595_rx #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          at;
    bit          ok;
    logic [39:0] fr;
  } ev_t;

  int          tests = 0;
  int          fails = 0;
  int          tk = 0;
  bit          check_en = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          valid_tk[$];
  int          stcp_tk = 0;

  logic        m_prev_sh, m_prev_st;
  logic [5:0]  slices[$];
  ev_t         pend[$];
  logic [39:0] m_frame = '0;
  logic [15:0] m_cnt = '0;
  logic        m_valid = 0;
  logic        m_err = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tk);
    end
  endtask

  // Frame-level model: each shcp rise contributes one 6-bit slice; a latch accepts exactly 8 slices
  task automatic modelStep(input logic r, input logic sh, input logic st, input logic [5:0] ds);
    ev_t ev;
    m_valid = 0;
    m_err   = 0;
    if (!r) begin
      m_prev_sh = 1;
      m_prev_st = 1;
      slices.delete();
      pend.delete();
      m_frame = '0;
      m_cnt   = '0;
      return;
    end
    if (sh && !m_prev_sh) slices.push_back(ds);
    if (st && !m_prev_st) begin
      ev.at = tk + LAT;
      ev.ok = (slices.size() == 8);
      ev.fr = '0;
      if (ev.ok) begin
        for (int i = 0; i < 8; i++) begin
          ev.fr[39-i] = slices[i][0];
          ev.fr[31-i] = slices[i][1];
          ev.fr[19-i] = slices[i][3];
          ev.fr[11-i] = slices[i][4];
          if (i < 4) begin
            ev.fr[23-i] = slices[i][2];
            ev.fr[3-i]  = slices[i][5];
          end
        end
      end
      pend.push_back(ev);
      slices.delete();
    end
    m_prev_sh = sh;
    m_prev_st = st;
    while (pend.size() > 0 && pend[0].at == tk) begin
      if (pend[0].ok) begin
        m_frame = pend[0].fr;
        m_cnt   = m_cnt + 16'd1;
        m_valid = 1;
      end else begin
        m_err = 1;
      end
      void'(pend.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sh, input logic st, input logic [5:0] ds);
    rst      = r;
    bus.shcp = sh;
    bus.stcp = st;
    bus.ds0  = ds[0];
    bus.ds1  = ds[1];
    bus.ds2  = ds[2];
    bus.ds3  = ds[3];
    bus.ds4  = ds[4];
    bus.ds5  = ds[5];
    @(posedge clk);
    tk++;
    modelStep(r, sh, st, ds);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 6'd0);
  endtask

  task automatic resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 6'd0);
      check_en = 1;
      checkOutput("rst_led_frame", 64'(bus.led_frame), 64'd0);
      checkOutput("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
      checkOutput("rst_valid_err", 64'({bus.frame_valid, bus.frame_err}), 64'd0);
    end
    idle(3);
    n_valid = 0;
    n_err   = 0;
    valid_tk.delete();
  endtask

  // One shcp high/low pair per bit, then stcp held for 'hold' cycles
  task automatic sendFrame(input logic [39:0] fr, input int npulse, input bit garb, input int hold);
    logic [5:0] ds;
    for (int i = 0; i < npulse; i++) begin
      ds = 6'd0;
      if (i < 8) begin
        ds[0] = fr[39-i];
        ds[1] = fr[31-i];
        ds[3] = fr[19-i];
        ds[4] = fr[11-i];
      end
      if (i < 4) begin
        ds[2] = fr[23-i];
        ds[5] = fr[3-i];
      end else if (garb) begin
        ds[2] = i[0];
        ds[5] = ~i[0];
      end
      applyStimulus(1, 1, 0, ds);
      applyStimulus(1, 0, 0, ds);
    end
    for (int h = 0; h < hold; h++) begin
      applyStimulus(1, 0, 1, 6'd0);
      if (h == 0) stcp_tk = tk;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("led_frame", 64'(bus.led_frame), 64'(m_frame));
      checkOutput("frame_cnt", 64'(bus.frame_cnt), 64'(m_cnt));
      checkOutput("frame_valid", 64'(bus.frame_valid), 64'(m_valid));
      checkOutput("frame_err", 64'(bus.frame_err), 64'(m_err));
      if (bus.frame_valid) begin
        n_valid++;
        valid_tk.push_back(tk);
      end
      if (bus.frame_err) n_err++;
    end
  end

  initial begin
    int base;
    rst = 0;
    bus.shcp = 0; bus.stcp = 0;
    bus.ds0 = 0; bus.ds1 = 0; bus.ds2 = 0; bus.ds3 = 0; bus.ds4 = 0; bus.ds5 = 0;

    // Single minimum-period frame
    resetDut();
    sendFrame(40'hA55AC33CF0, 8, 0, 1);
    idle(4);
    checkOutput("t1_led_frame", 64'(bus.led_frame), 64'h00A55AC33CF0);
    checkOutput("t1_model_frame", 64'(m_frame), 64'h00A55AC33CF0);
    checkOutput("t1_frame_cnt", 64'(bus.frame_cnt), 64'd1);
    checkOutput("t1_valid_pulses", 64'(n_valid), 64'd1);
    checkOutput("t1_err_pulses", 64'(n_err), 64'd0);
    if (valid_tk.size() > 0) checkOutput("t1_valid_tick", 64'(valid_tk[0]), 64'(stcp_tk + LAT));

    // Back-to-back frames with no idle gap
    resetDut();
    sendFrame(40'h0000000001, 8, 0, 1);
    sendFrame(40'h8000000000, 8, 0, 1);
    sendFrame(40'hFFFFFFFFFF, 8, 0, 1);
    idle(4);
    checkOutput("t2_led_frame", 64'(bus.led_frame), 64'h00FFFFFFFFFF);
    checkOutput("t2_frame_cnt", 64'(bus.frame_cnt), 64'd3);
    checkOutput("t2_valid_pulses", 64'(n_valid), 64'd3);
    if (valid_tk.size() == 3) begin
      checkOutput("t2_spacing_a", 64'(valid_tk[1] - valid_tk[0]), 64'd17);
      checkOutput("t2_spacing_b", 64'(valid_tk[2] - valid_tk[1]), 64'd17);
    end

    // Short (7) and long (9) frames are rejected without disturbing the last good frame
    resetDut();
    sendFrame(40'h0F0F0F0F0F, 8, 0, 1);
    sendFrame(40'h1111111111, 7, 0, 1);
    sendFrame(40'h2222222222, 9, 0, 1);
    idle(4);
    checkOutput("t3_err_pulses", 64'(n_err), 64'd2);
    checkOutput("t3_led_held", 64'(bus.led_frame), 64'h000F0F0F0F0F);
    checkOutput("t3_cnt_held", 64'(bus.frame_cnt), 64'd1);
    sendFrame(40'h3C3C3C3C3C, 8, 0, 1);
    idle(4);
    checkOutput("t3_led_good", 64'(bus.led_frame), 64'h003C3C3C3C3C);
    checkOutput("t3_cnt_good", 64'(bus.frame_cnt), 64'd2);

    // Short lanes ignore data after the 4th shift
    resetDut();
    sendFrame(40'h0000A0000A, 8, 1, 1);
    idle(4);
    checkOutput("t4_lane2", 64'(bus.led_frame[23:20]), 64'hA);
    checkOutput("t4_lane5", 64'(bus.led_frame[3:0]), 64'hA);
    checkOutput("t4_frame", 64'(bus.led_frame), 64'h00000A0000A);

    // Reset mid-frame discards the partial frame
    resetDut();
    sendFrame(40'h5555555555, 8, 0, 1);
    sendFrame(40'hFFFFFFFFFF, 4, 0, 0);
    resetDut();
    sendFrame(40'h123456789A, 8, 0, 1);
    idle(4);
    checkOutput("t5_led_frame", 64'(bus.led_frame), 64'h00123456789A);
    checkOutput("t5_frame_cnt", 64'(bus.frame_cnt), 64'd1);
    sendFrame(40'hFFFFFFFFFF, 4, 0, 0);
    resetDut();
    sendFrame(40'hFFFFFFFFFF, 4, 0, 1);
    idle(4);
    checkOutput("t5_partial_err", 64'(n_err), 64'd1);
    checkOutput("t5_partial_cnt", 64'(bus.frame_cnt), 64'd0);

    // shcp held high across reset release must not count as an edge
    applyStimulus(1, 1, 0, 6'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 6'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 6'd0);
    idle(2);
    n_valid = 0;
    n_err = 0;
    sendFrame(40'hC3C3C3C3C3, 8, 0, 1);
    idle(4);
    checkOutput("t5_hold_valid", 64'(n_valid), 64'd1);
    checkOutput("t5_hold_err", 64'(n_err), 64'd0);
    checkOutput("t5_hold_frame", 64'(bus.led_frame), 64'h00C3C3C3C3C3);

    // A long latch strobe is a single event
    resetDut();
    sendFrame(40'h9876543210, 8, 0, 5);
    idle(4);
    base = valid_tk.size() > 0 ? valid_tk[0] : -1;
    checkOutput("t6_valid_pulses", 64'(n_valid), 64'd1);
    checkOutput("t6_err_pulses", 64'(n_err), 64'd0);
    checkOutput("t6_valid_tick", 64'(base), 64'(stcp_tk + LAT));
    checkOutput("t6_frame_cnt", 64'(bus.frame_cnt), 64'd1);
    sendFrame(40'h0123456789, 8, 0, 1);
    idle(4);
    checkOutput("t6_next_frame", 64'(bus.led_frame), 64'h000123456789);
    checkOutput("t6_next_cnt", 64'(bus.frame_cnt), 64'd2);

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hc595_rx.md
# hc595_rx

Serial-to-parallel capture block for the 6-lane HC595 LED backlight link. It samples the shift clock, latch strobe and six data lanes that drive the local-dimming LED shift-register chain, and rebuilds the 40-bit LED on/off frame. It then presents the frame with a one-cycle valid pulse and a framing-error flag. It is used as the loop-back monitor and in system benches to confirm what the LED board actually latched.

## Interface
- `CNT_W`, default 16: width of the valid-frame counter.
- `clk` input 1: system clock. It is the same clock that drives the transmitter.
- `rst` input 1: reset, synchronous, active-low.
- `shcp` input 1: shift clock. Data is sampled on its rising edge.
- `stcp` input 1: storage (latch) strobe. Its rising edge ends the frame.
- `ds0`, `ds1`, `ds3`, `ds4` input 1 each: long lanes, 8 bits per frame.
- `ds2`, `ds5` input 1 each: short lanes, 4 bits per frame.
- `led_frame` output 40: last good frame. Bit 39 is LED0 and bit 0 is LED39.
- `frame_valid` output 1: one-cycle pulse when `led_frame` updates.
- `frame_err` output 1: one-cycle pulse when a frame is rejected.
- `frame_cnt` output CNT_W: count of accepted frames. It wraps modulo 2^CNT_W.

## Operation
- Edge detection compares the current sample of `shcp` and `stcp` against the previous sample.
  - Both previous-sample registers reset to 1, so a line held high through reset is not seen as an edge.
- `bit_cnt` (4 bits) counts `shcp` rising edges since the last `stcp` rising edge or reset. It saturates at 15.
- Each `shcp` rising edge shifts every long lane: `lane <= {lane[6:0], ds}`. The first bit received ends up in the MSB.
- Short lanes shift only while `bit_cnt < 4`. Later edges leave them unchanged, and data on `ds2`/`ds5` is ignored after the 4th edge.
- Frame assembly, MSB first:
  - `led_frame[39:32]` = lane0
  - `[31:24]` = lane1
  - `[23:20]` = lane2
  - `[19:12]` = lane3
  - `[11:4]` = lane4
  - `[3:0]` = lane5
- On an `stcp` rising edge:
  - If the effective bit count is exactly 8: load `led_frame`, pulse `frame_valid`, and increment `frame_cnt`.
  - Otherwise: pulse `frame_err`. `led_frame` and `frame_cnt` are held.
  - In both cases `bit_cnt` and all lane shift registers clear to 0.
- If an `shcp` rising edge and an `stcp` rising edge are detected in the same cycle, the shift is applied first. That bit is part of the frame and counts toward the 8.
- `stcp` held high for several cycles is one event. The next frame needs `stcp` to go low and rise again.
- `frame_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `led_frame` = 0, `frame_valid` = 0, `frame_err` = 0, `frame_cnt` = 0, `bit_cnt` = 0, lanes = 0, edge-detect history = 1.
- Reset taken mid-frame discards the partial frame. The next `stcp` rising edge after fewer than 8 fresh `shcp` edges gives `frame_err`.
- Latency without synchronizers:
  - Define edge k as the first clock edge at which `stcp` is sampled 1 after a sample of 0.
  - `led_frame`, `frame_cnt` and `frame_valid` (or `frame_err`) are registered at edge k.
  - The pulse lasts exactly one cycle.
- The block accepts the minimum transmitter frame: `shcp` high/low one cycle each, 8 pulses, then `stcp`, for a 17-cycle period. It also accepts back-to-back frames with no idle gap.
- Data lanes are sampled in the same cycle as the `shcp` rising edge is detected, so the lanes must be stable while `shcp` is high.

## Configuration
- `HC595_RX_SYNC_EN` defined:
  - Adds a 2-flop synchronizer on each of the 8 serial inputs.
  - All latencies increase by 2 cycles.
  - Lane-to-clock alignment is preserved because every input is delayed equally.
  - Use it when the link comes from an external board.
- `HC595_RX_SYNC_EN` not defined: inputs are used directly, with the same-clock timing above.

## Test plan
- Single frame:
  - Stimulus: send LED0..LED39 = 40'hA55AC33CF0 with the 17-cycle sequence.
  - Required: `led_frame` = 40'hA55AC33CF0, `frame_valid` high exactly one cycle at edge k, `frame_cnt` = 1, `frame_err` never high.
- Back-to-back frames:
  - Stimulus: send 40'h0000000001, 40'h8000000000 and 40'hFFFFFFFFFF with no gap.
  - Required: three `frame_valid` pulses 17 cycles apart with matching frames, `frame_cnt` = 3.
- Short and long frames:
  - Stimulus: 7 `shcp` pulses then `stcp`; next, 9 pulses then `stcp`.
  - Required: `frame_err` pulses twice, `led_frame` and `frame_cnt` unchanged.
  - Then a correct frame: accepted normally.
- Short-lane masking:
  - Stimulus: toggle `ds2`/`ds5` during shcp edges 5-8 of a frame whose first 4 bits are 4'b1010.
  - Required: `led_frame[23:20]` = `led_frame[3:0]` = 4'b1010.
- Reset handling:
  - Stimulus: assert `rst` after 4 `shcp` pulses, release, then send a full frame 40'h123456789A.
  - Required: all outputs 0 during reset; frame captured correctly; `frame_cnt` = 1.
  - Stimulus: `shcp` held high through reset release.
  - Required: no edge is counted.
- Long latch strobe:
  - Stimulus: hold `stcp` high for 5 cycles after a valid frame.
  - Required: a single `frame_valid` pulse.
  - Variant: repeat with `HC595_RX_SYNC_EN` defined.
  - Required: the same results, 2 cycles later.
